// File: rtl/fpu_arb_pkg.sv
// Shared types and helpers for the fpau share arbiter.
// The op-code width normally comes from fpu_params.h; a fallback keeps this slice standalone.
`ifndef FPU_OP_WIDTH
`define FPU_OP_WIDTH 4
`endif

package fpu_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  localparam int TIMEOUT_DEF = 15;

  function automatic int clog2(input int n);
    for (int w = 1; w < 32; w++) begin
      if ((1 << w) >= n) return w;
    end
    return 32;
  endfunction

endpackage

// File: rtl/fpu_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module fpu_rr_pick
  import fpu_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          found
);

  logic [PW-1:0] cand;

  // Scan from the far end so the smallest offset wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int off = N - 1; off >= 0; off--) begin
      cand = PW'((int'(ptr) + off) % N);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    if (found) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/fpu_share_arbiter.sv
// Round-robin sharing of one fpau between N_REQ requesters,
// with latched operands, registered response and an ISSUE watchdog.
module fpu_share_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int OP_W    = `FPU_OP_WIDTH,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*OP_W-1:0] req_op,
  input  logic [N_REQ*32-1:0]   req_x1,
  input  logic [N_REQ*32-1:0]   req_x2,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [31:0]           rsp_y32,
  output logic                  rsp_y1,
  output logic                  rsp_err,
  output logic [OP_W-1:0]       fpu_op,
  output logic [31:0]           fpu_x1,
  output logic [31:0]           fpu_x2,
  output logic                  fpu_ready,
  input  logic                  fpu_valid,
  input  logic [31:0]           fpu_y32,
  input  logic                  fpu_y1
);

  localparam int PW = clog2(N_REQ);
  localparam int WW = clog2(TIMEOUT);

  state_t state_q, state_d;

  logic [PW-1:0]    ptr_q;
  logic [PW-1:0]    owner_q;
  logic [OP_W-1:0]  op_q;
  logic [31:0]      x1_q;
  logic [31:0]      x2_q;
  logic [WW-1:0]    wd_q;

  logic [N_REQ-1:0] pick_gnt;
  logic [PW-1:0]    pick_idx;
  logic             pick_found;

  logic [OP_W-1:0]  sel_op;
  logic [31:0]      sel_x1;
  logic [31:0]      sel_x2;

  logic             grant;
  logic             done;
  logic             expired;

  fpu_rr_pick #(
    .N  (N_REQ),
    .PW (PW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    sel_op = '0;
    sel_x1 = '0;
    sel_x2 = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == PW'(i)) begin
        sel_op = req_op[i*OP_W +: OP_W];
        sel_x1 = req_x1[i*32 +: 32];
        sel_x2 = req_x2[i*32 +: 32];
      end
    end
  end

  assign expired = (wd_q == WW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (pick_found) state_d = ISSUE;
      ISSUE: if (fpu_valid || expired) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Gated by rst so the handshakes drop in the reset cycle itself.
  always_comb begin
    req_ready = '0;
    fpu_ready = 1'b0;
    grant     = 1'b0;
    done      = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          grant     = pick_found;
          req_ready = pick_gnt;
        end
        ISSUE: begin
          fpu_ready = 1'b1;
          done      = fpu_valid || expired;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      owner_q   <= '0;
      op_q      <= '0;
      x1_q      <= '0;
      x2_q      <= '0;
      wd_q      <= '0;
      rsp_valid <= '0;
      rsp_y32   <= '0;
      rsp_y1    <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      if (grant) begin
        owner_q <= pick_idx;
        ptr_q   <= (pick_idx == PW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
        op_q    <= sel_op;
        x1_q    <= sel_x1;
        x2_q    <= sel_x2;
        wd_q    <= '0;
      end else if (fpu_ready && !done) begin
        wd_q <= wd_q + 1'b1;
      end
      rsp_valid <= '0;
      if (done) begin
        rsp_valid[owner_q] <= 1'b1;
        rsp_y32 <= fpu_valid ? fpu_y32 : '0;
        rsp_y1  <= fpu_valid & fpu_y1;
        rsp_err <= !fpu_valid;
      end
    end
  end

  assign fpu_op = op_q;
  assign fpu_x1 = x1_q;
  assign fpu_x2 = x2_q;

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Directed bench for fpu_share_arbiter with a small fpau stub
// whose latency can be set per op or made to never complete.
module tb_fpu_share_arbiter;

  localparam int N   = 2;
  localparam int OW  = 4;
  localparam int TO  = 15;

  localparam logic [OW-1:0] OP_FADD = 4'h1;
  localparam logic [OW-1:0] OP_FMUL = 4'h3;
  localparam logic [OW-1:0] OP_FCLT = 4'h8;
  localparam logic [OW-1:0] OP_XTRA = 4'hF;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*OW-1:0] req_op = '0;
  logic [N*32-1:0] req_x1 = '0;
  logic [N*32-1:0] req_x2 = '0;
  logic [N-1:0]    rsp_valid;
  logic [31:0]     rsp_y32;
  logic            rsp_y1;
  logic            rsp_err;
  logic [OW-1:0]   fpu_op;
  logic [31:0]     fpu_x1;
  logic [31:0]     fpu_x2;
  logic            fpu_ready;
  logic            fpu_valid;
  logic [31:0]     fpu_y32;
  logic            fpu_y1;

  int nvec = 0;
  int mis  = 0;

  int  lat  = 1;
  bit  dead = 1'b0;
  logic [7:0] cnt;

  always #5 clk = ~clk;

  fpu_share_arbiter #(
    .N_REQ   (N),
    .OP_W    (OW),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_x1    (req_x1),
    .req_x2    (req_x2),
    .rsp_valid (rsp_valid),
    .rsp_y32   (rsp_y32),
    .rsp_y1    (rsp_y1),
    .rsp_err   (rsp_err),
    .fpu_op    (fpu_op),
    .fpu_x1    (fpu_x1),
    .fpu_x2    (fpu_x2),
    .fpu_ready (fpu_ready),
    .fpu_valid (fpu_valid),
    .fpu_y32   (fpu_y32),
    .fpu_y1    (fpu_y1)
  );

  // fpau stub: answers lat cycles into the op, or never when dead.
  always_ff @(posedge clk) begin
    if (!fpu_ready || fpu_valid) cnt <= '0;
    else                         cnt <= cnt + 8'd1;
  end

  always_comb begin
    fpu_valid = fpu_ready && !dead && (int'(cnt) == lat - 1);
    fpu_y32   = '0;
    fpu_y1    = 1'b0;
    case (fpu_op)
      OP_FADD:
        if (fpu_x1 == 32'h3F800000 && fpu_x2 == 32'h40000000)
          fpu_y32 = 32'h40400000;
      OP_FMUL:
        if (fpu_x1 == 32'h40000000 && fpu_x2 == 32'h40400000)
          fpu_y32 = 32'h40C00000;
      OP_FCLT: fpu_y1 = (fpu_x1 < fpu_x2);
      default: fpu_y32 = fpu_x1 + fpu_x2;
    endcase
  end

  typedef struct {
    int            r;
    logic [OW-1:0] op;
    logic [31:0]   x1;
    logic [31:0]   x2;
    int            lat;
    bit            dead;
    logic [31:0]   y32;
    logic          y1;
    logic          err;
    int            elat;
  } vec_t;

  vec_t tbl [8];
  logic [31:0] ey [N];

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1;
    req_valid = '0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic set_req(input int r, input logic [OW-1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    req_op[r*OW +: OW] = op;
    req_x1[r*32 +: 32] = a;
    req_x2[r*32 +: 32] = b;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    dead = v.dead;
    lat  = v.lat;
    set_req(v.r, v.op, v.x1, v.x2);
    req_valid = N'(1) << v.r;
    @(negedge clk);
    n = 0;
    while (req_ready == '0 && n < 10) begin
      cyc();
      @(negedge clk);
      n++;
    end
    chk("grant", 128'(req_ready), 128'(N'(1) << v.r));
    cyc();
    req_valid = '0;
    @(negedge clk);
    n = 1;
    while (rsp_valid == '0 && n < 40) begin
      if (fpu_ready)
        chk("fpu_operands", {fpu_op, fpu_x1, fpu_x2}, {v.op, v.x1, v.x2});
      cyc();
      @(negedge clk);
      n++;
    end
    chk("latency", 128'(n), 128'(v.elat));
    chk("rsp_valid", 128'(rsp_valid), 128'(N'(1) << v.r));
    chk("rsp_y32", 128'(rsp_y32), 128'(v.y32));
    chk("rsp_y1", 128'(rsp_y1), 128'(v.y1));
    chk("rsp_err", 128'(rsp_err), 128'(v.err));
    cyc();
  endtask

  // Holds req_valid=mask until nops grants; expects alternation when both set.
  task automatic stream(input int nops, input logic [N-1:0] mask);
    int c, ng, nr, cur, expg, lastc;
    ng = 0; nr = 0; cur = 0; expg = 0; lastc = 0; c = 0;
    req_valid = mask;
    @(negedge clk);
    while (c < 80 && nr < nops) begin
      if (rsp_valid != '0) begin
        chk("stream_rsp_owner", 128'(rsp_valid), 128'(N'(1) << cur));
        chk("stream_rsp_y32", 128'(rsp_y32), 128'(ey[cur]));
        nr++;
      end
      if (req_ready != '0) begin
        chk("stream_grant", 128'(req_ready), 128'(N'(1) << expg));
        if (ng > 0) chk("stream_gap", 128'(c - lastc), 128'(2));
        lastc = c;
        cur   = expg;
        if (mask == 2'b11) expg = 1 - expg;
        ng++;
      end
      cyc();
      if (ng >= nops) req_valid = '0;
      @(negedge clk);
      c++;
    end
    chk("stream_count", 128'(nr), 128'(nops));
    cyc();
  endtask

  initial begin
    tbl[0] = '{0, OP_FADD, 32'h3F800000, 32'h40000000, 1, 1'b0,
               32'h40400000, 1'b0, 1'b0, 2};
    tbl[1] = '{1, OP_FCLT, 32'h3F800000, 32'h40000000, 1, 1'b0,
               32'h0, 1'b1, 1'b0, 2};
    tbl[2] = '{1, OP_FCLT, 32'h40000000, 32'h3F800000, 1, 1'b0,
               32'h0, 1'b0, 1'b0, 2};
    tbl[3] = '{0, OP_FMUL, 32'h40000000, 32'h40400000, 1, 1'b0,
               32'h40C00000, 1'b0, 1'b0, 2};
    tbl[4] = '{0, OP_FMUL, 32'h40000000, 32'h40400000, 3, 1'b0,
               32'h40C00000, 1'b0, 1'b0, 4};
    tbl[5] = '{1, OP_FADD, 32'h3F800000, 32'h40000000, 1, 1'b1,
               32'h0, 1'b0, 1'b1, TO + 1};
    tbl[6] = '{1, OP_FADD, 32'h3F800000, 32'h40000000, 1, 1'b0,
               32'h40400000, 1'b0, 1'b0, 2};
    tbl[7] = '{0, OP_XTRA, 32'h00000005, 32'h00000007, 2, 1'b0,
               32'h0000000C, 1'b0, 1'b0, 3};

    // Reset state, with a request present while rst is high.
    req_valid = 2'b11;
    cyc();
    cyc();
    @(negedge clk);
    chk("rst_req_ready", 128'(req_ready), 128'(0));
    chk("rst_rsp", {rsp_valid, rsp_y32, rsp_y1, rsp_err}, 128'(0));
    chk("rst_fpu", {fpu_ready, fpu_op, fpu_x1, fpu_x2}, 128'(0));
    req_valid = '0;
    cyc();
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(tbl[i]);

    // Rotation with both requesters held valid.
    do_reset();
    dead = 1'b0;
    lat  = 1;
    set_req(0, OP_XTRA, 32'h000000A0, 32'h00000001);
    set_req(1, OP_XTRA, 32'h000000B0, 32'h00000002);
    ey[0] = 32'h000000A1;
    ey[1] = 32'h000000B2;
    stream(8, 2'b11);

    // Back-to-back FMUL from requester 0.
    do_reset();
    set_req(0, OP_FMUL, 32'h40000000, 32'h40400000);
    ey[0] = 32'h40C00000;
    ey[1] = 32'h0;
    stream(4, 2'b01);

    // Reset in the middle of an op that never completes.
    do_reset();
    dead = 1'b1;
    set_req(0, OP_XTRA, 32'h000000A0, 32'h00000001);
    set_req(1, OP_XTRA, 32'h000000B0, 32'h00000002);
    req_valid = 2'b01;
    @(negedge clk);
    chk("mid_grant", 128'(req_ready), 128'(2'b01));
    cyc();
    req_valid = '0;
    @(negedge clk);
    chk("mid_issue", 128'(fpu_ready), 128'(1));
    cyc();
    cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", {fpu_ready, rsp_valid}, 128'(0));
    cyc();
    rst = 1'b0;
    dead = 1'b0;
    @(negedge clk);
    chk("mid_after_ready", {fpu_ready, rsp_valid}, 128'(0));
    cyc();
    req_valid = 2'b11;
    @(negedge clk);
    chk("mid_first_grant", 128'(req_ready), 128'(2'b01));
    cyc();
    req_valid = '0;
    @(negedge clk);
    chk("mid_no_rsp", 128'(rsp_valid), 128'(0));
    cyc();
    @(negedge clk);
    chk("mid_rsp", {rsp_valid, rsp_y32, rsp_err},
        {2'b01, 32'h000000A1, 1'b0});
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, mis);
    $finish;
  end

endmodule
